// File: rtl/mips_pkg.sv
// Shared MD-unit definitions: md_op encodings, FSM state encodings
// and small decode helpers used by the controller and the arithmetic block.
package mips_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    function automatic logic is_mult_op(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath. Produces {hi,lo} for the latched
// operands and op; signed division is done on magnitudes so that the
// INT_MIN / -1 and divide-by-zero corners never reach a raw signed divider.
module md_alu
    import mips_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Product from extended operands, quotient/remainder from magnitudes, then select by op
    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        a_neg     = is_signed & a[31];
        b_neg     = is_signed & b[31];

        a_ext   = {{32{a_neg}}, a};
        b_ext   = {{32{b_neg}}, b};
        product = a_ext * b_ext;

        a_mag  = a_neg ? (32'd0 - a) : a;
        b_mag  = b_neg ? (32'd0 - b) : b;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;

        result = 64'd0;
        case (op)
            MD_MULT, MD_MULTU: begin
                result = product;
            end
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) begin
                    result = {a, 32'hFFFF_FFFF};
                end else if ((op == MD_DIV) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    result = {32'h0000_0000, 32'h8000_0000};
                end else begin
                    result = {rem, quot};
                end
            end
            default: begin
                result = 64'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller: IDLE/MULT/DIV FSM with a 4-bit down-counter
// modelling the unit latency, operand latches, and the committed HI/LO pair.
// The result is computed combinationally from the latched operands and
// written on the edge that ends the last busy cycle.
module md_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    input  logic        md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    md_state_t   state;
    md_state_t   state_next;
    md_op_t      op_in;
    md_op_t      op_q;
    logic [3:0]  count;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] alu_result;
    logic        idle;
    logic        start_ok;
    logic        start_mult;
    logic        start_div;
    logic        start_accepted;
    logic        done;

    assign op_in          = md_op_t'(md_op);
    assign idle           = (state == ST_IDLE);
    assign start_ok       = start & ~flush;
    assign start_mult     = start_ok & is_mult_op(op_in);
    assign start_div      = start_ok & is_div_op(op_in);
    assign start_accepted = start_mult | start_div;
    assign done           = ~idle & (count == 4'd1);

    md_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: only an idle unit accepts work; a running op always finishes
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_mult) begin
                    state_next = ST_MULT;
                end else if (start_div) begin
                    state_next = ST_DIV;
                end
            end
            ST_MULT, ST_DIV: begin
                if (done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs: busy while not idle; stall the MD/mfhi/mflo user while busy or on issue
    always_comb begin
        busy     = ~idle;
        md_stall = md_use & (~idle | start_accepted);
    end

    // Latency counter and operand latches, loaded when an op is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 4'd0;
            op_q  <= MD_NONE;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
        end else if (idle) begin
            if (start_accepted) begin
                count <= start_mult ? MULT_CNT : DIV_CNT;
                op_q  <= op_in;
                a_q   <= rs_data;
                b_q   <= rt_data;
            end
        end else begin
            count <= count - 4'd1;
        end
    end

    // HI/LO: commit on the final busy edge, or direct moves while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (done) begin
            hi <= alu_result[63:32];
            lo <= alu_result[31:0];
        end else if (idle && start_ok && (op_in == MD_MTHI)) begin
            hi <= rs_data;
        end else if (idle && start_ok && (op_in == MD_MTLO)) begin
            lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: issues each op from a negedge, counts busy
// cycles, and compares HI/LO, busy and md_stall against hand-computed values.
module tb_md_ctrl;
    import mips_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    md_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .md_op    (md_op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .flush    (flush),
        .md_use   (md_use),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div at the current negedge and follow it to completion.
    // inject: 0 nothing, 1 flush in busy cycle 2, 2 mtlo 0xDEADBEEF in busy cycle 2
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic use_in, input int inject,
                                 input int exp_cycles);
        int cycles;
        start   = 1'b1;
        md_op   = op;
        rs_data = a;
        rt_data = b;
        md_use  = use_in;
        flush   = 1'b0;
        #1;
        checkOutput({tag, " stall_issue"}, 64'(md_stall), 64'(use_in));
        @(negedge clk);
        start  = 1'b0;
        md_op  = 3'd0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            if (cycles == 2) begin
                checkOutput({tag, " stall_busy"}, 64'(md_stall), 64'(use_in));
            end
            if (cycles == 2 && inject == 1) begin
                flush = 1'b1;
            end else if (cycles == 2 && inject == 2) begin
                start   = 1'b1;
                md_op   = MD_MTLO;
                rs_data = 32'hDEAD_BEEF;
            end else begin
                flush = 1'b0;
                start = 1'b0;
                md_op = 3'd0;
            end
            @(negedge clk);
        end
        start  = 1'b0;
        flush  = 1'b0;
        md_op  = 3'd0;
        md_use = 1'b0;
        checkOutput({tag, " busy_cycles"}, 64'(cycles), 64'(exp_cycles));
    endtask

    // Directed sequence
    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        md_op   = 3'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        flush   = 1'b0;
        md_use  = 1'b0;

        @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset hilo", {hi, lo}, 64'd0);
        checkOutput("reset stall", 64'(md_stall), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        applyStimulus("mult 3*5", MD_MULT, 32'd3, 32'd5, 1'b1, 0, 5);
        checkOutput("mult 3*5 hilo", {hi, lo}, 64'h0000_0000_0000_000F);
        #1;
        checkOutput("stall after done", 64'(md_stall), 64'd0);

        applyStimulus("mult -1*2", MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 5);
        checkOutput("mult -1*2 hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 5);
        checkOutput("multu hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        applyStimulus("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 10);
        checkOutput("div -7/2 hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, 10);
        checkOutput("div 7/-2 hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        applyStimulus("divu 7/2", MD_DIVU, 32'd7, 32'd2, 1'b0, 0, 10);
        checkOutput("divu 7/2 hilo", {hi, lo}, 64'h0000_0001_0000_0003);
        applyStimulus("div 5/0", MD_DIV, 32'd5, 32'd0, 1'b0, 0, 10);
        checkOutput("div 5/0 hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        applyStimulus("divu x/0", MD_DIVU, 32'h8000_0010, 32'd0, 1'b0, 0, 10);
        checkOutput("divu x/0 hilo", {hi, lo}, 64'h8000_0010_FFFF_FFFF);
        applyStimulus("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 10);
        checkOutput("div min/-1 hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        // Direct moves while idle
        start   = 1'b1;
        md_op   = MD_MTHI;
        rs_data = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        checkOutput("mthi hi", 64'(hi), 64'h1234);
        checkOutput("mthi lo kept", 64'(lo), 64'h8000_0000);
        checkOutput("mthi busy", 64'(busy), 64'd0);
        start   = 1'b1;
        md_op   = MD_MTLO;
        rs_data = 32'h0000_ABCD;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        checkOutput("mtlo hilo", {hi, lo}, 64'h0000_1234_0000_ABCD);

        // mtlo while busy is dropped
        applyStimulus("mult mtlo-busy", MD_MULT, 32'd3, 32'd5, 1'b1, 2, 5);
        checkOutput("mtlo-busy hilo", {hi, lo}, 64'h0000_0000_0000_000F);

        // Flushed start is suppressed
        start   = 1'b1;
        md_op   = MD_MULT;
        rs_data = 32'd7;
        rt_data = 32'd9;
        flush   = 1'b1;
        md_use  = 1'b1;
        #1;
        checkOutput("flush start stall", 64'(md_stall), 64'd0);
        @(negedge clk);
        start  = 1'b0;
        flush  = 1'b0;
        md_op  = 3'd0;
        md_use = 1'b0;
        checkOutput("flush start busy", 64'(busy), 64'd0);
        repeat (6) @(negedge clk);
        checkOutput("flush start hilo", {hi, lo}, 64'h0000_0000_0000_000F);

        // None / reserved ops do nothing
        start = 1'b1;
        md_op = 3'd0;
        rs_data = 32'h5555_5555;
        @(negedge clk);
        md_op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        checkOutput("none/rsvd busy", 64'(busy), 64'd0);
        checkOutput("none/rsvd hilo", {hi, lo}, 64'h0000_0000_0000_000F);

        // Flush mid-div still commits
        applyStimulus("divu flush-busy", MD_DIVU, 32'd100, 32'd7, 1'b0, 1, 10);
        checkOutput("divu flush-busy hilo", {hi, lo}, 64'h0000_0002_0000_000E);

        // Reset in the 3rd busy cycle of a mult
        start   = 1'b1;
        md_op   = MD_MULT;
        rs_data = 32'd3;
        rt_data = 32'd5;
        md_use  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre-reset busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset stall", 64'(md_stall), 64'd0);
        checkOutput("mid reset hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        md_use  = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("no late commit busy", 64'(busy), 64'd0);
        checkOutput("no late commit hilo", {hi, lo}, 64'd0);

        // First edge after reset release accepts a start
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus("post-reset mult", MD_MULT, 32'd6, 32'd7, 1'b0, 0, 5);
        checkOutput("post-reset hilo", {hi, lo}, 64'h0000_0000_0000_002A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 5, is the number of busy cycles for mult/multu (legal range 1..15).
REQ-002 Parameter DIV_LAT, default 10, is the number of busy cycles for div/divu (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  an MD instruction is issued from E stage this cycle.
REQ-006 md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is reserved and treated as none.
REQ-007 rs_data  input  32  operand A (dividend or multiplicand; source for mthi/mtlo).
REQ-008 rt_data  input  32  operand B (divisor or multiplier).
REQ-009 flush  input  1  exception/eret cancels the E-stage instruction this cycle.
REQ-010 md_use  input  1  the E-stage instruction is an MD instruction or mfhi/mflo.
REQ-011 busy  output  1  a multiply or divide is in progress.
REQ-012 md_stall  output  1  stall request to the hazard unit.
REQ-013 hi  output  32  committed HI register.
REQ-014 lo  output  32  committed LO register.

Function
REQ-015 The block SHALL implement the states IDLE, MULT and DIV.
REQ-016 In IDLE, start=1 with flush=0 and md_op mult/multu SHALL latch the operands, load the down-counter with MULT_LAT and enter MULT.
REQ-017 In IDLE, start=1 with flush=0 and md_op div/divu SHALL latch the operands, load the down-counter with DIV_LAT and enter DIV.
REQ-018 In IDLE, start=1 with flush=0 and md_op mthi (mtlo) SHALL write rs_data to hi (lo) at that edge, taking effect in the next cycle, with no busy period.
REQ-019 busy SHALL equal (state != IDLE).
REQ-020 For a start sampled at edge t, busy SHALL be high for exactly LAT cycles after t.
REQ-021 hi and lo SHALL update at the edge that ends the last busy cycle, and state SHALL return to IDLE at that same edge.
REQ-022 mult and multu SHALL produce a 64-bit product ({hi,lo}), signed for mult and unsigned for multu.
REQ-023 div and divu SHALL write the quotient to lo and the remainder to hi, signed for div and unsigned for divu.
REQ-024 Signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-025 Division by zero SHALL set lo=32'hFFFF_FFFF and hi=dividend, for both signed and unsigned division.
REQ-026 Signed 0x80000000 / -1 SHALL give lo=32'h8000_0000 and hi=0.
REQ-027 start while busy=1 SHALL be ignored, including mthi/mtlo; upstream is already stalled by md_stall.
REQ-028 flush=1 SHALL suppress any start in the same cycle.
REQ-029 flush while busy SHALL NOT abort the operation in progress; the issued operation always commits.
REQ-030 md_stall SHALL equal md_use & (busy | start_accepted), where start_accepted = start & ~flush & md_op in {mult, multu, div, divu}.
REQ-031 md_op none or reserved with start=1 SHALL have no effect.
REQ-032 hi and lo SHALL hold their values in every cycle not covered by REQ-018 or REQ-021.

Reset
REQ-033 reset_n low SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, busy=0 and md_stall=0 (latched operands also cleared).
REQ-034 Reset asserted mid-operation SHALL discard the pending result; hi and lo SHALL read 0 after reset.
REQ-035 After reset_n deasserts, the first rising edge SHALL accept a start normally.

Structure
REQ-036 The md_op encodings and the state encodings SHALL be defined in the shared package mips_pkg.
REQ-037 The arithmetic SHALL be placed in one sub-module, md_alu: combinational, 64-bit result for the latched operands and op, including the REQ-025/026 special cases.
REQ-038 md_ctrl SHALL contain the FSM, the 4-bit down-counter, the operand latches and the hi/lo registers.

Verification
REQ-039 Scenario: mult rs=3, rt=5 -> busy high 5 cycles, then hi=0, lo=15; md_stall high throughout while md_use=1.
REQ-040 Scenario: mult rs=-1, rt=2 -> hi=FFFFFFFF, lo=FFFFFFFE; multu with the same operands -> hi=00000001, lo=FFFFFFFE.
REQ-041 Scenario: div rs=-7, rt=2 -> 10 busy cycles, then lo=FFFFFFFD, hi=FFFFFFFF; divu rs=7, rt=2 -> lo=3, hi=1; div rs=5, rt=0 -> lo=FFFFFFFF, hi=5.
REQ-042 Scenario: mthi 0x1234 while idle -> hi=0x1234 next cycle with busy=0; mtlo issued while busy -> ignored, lo equals the result of the pending operation.
REQ-043 Scenario: start mult together with flush -> busy stays 0 and hi/lo are unchanged; flush during a div -> the div still commits.
REQ-044 Scenario: reset_n pulsed low in the 3rd busy cycle of a mult -> busy=0 and hi=lo=0 immediately, and no late commit occurs.
